// File: rtl/serial_frame_receiver_if.sv
// Bus between a serial bit source / word consumer and the serial frame receiver.
// The master drives the bit stream and consumer ready; the slave returns the received word and status.
interface serial_frame_receiver_if #(
    parameter int unsigned DATA_W = 8
);
    logic              en;
    logic              din;
    logic              ready;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    modport master (
        output en, din, ready,
        input  data_out, valid, parity_err, frame_err, overrun, busy
    );

    modport slave (
        input  en, din, ready,
        output data_out, valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Strobed LSB-first serial frame receiver (start, DATA_W data bits, optional parity, stop)
// with a one-word valid/ready output holding register and a sticky overrun flag.
module serial_frame_receiver #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_frame_receiver_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   bitCnt_q,    bitCnt_d;
    logic [DATA_W-1:0]  shift_q,     shift_d;
    logic               parityBit_q, parityBit_d;
    logic [DATA_W-1:0]  data_q,      data_d;
    logic               valid_q,     valid_d;
    logic               parityErr_q, parityErr_d;
    logic               frameErr_q,  frameErr_d;
    logic               overrun_q,   overrun_d;
    logic               frameDone;
    logic               newParityErr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parityBit_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parityBit_q <= parityBit_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            parityErr_q <= parityErr_d;
            frameErr_q  <= frameErr_d;
            overrun_q   <= overrun_d;
        end
    end

    // The parity check uses the stored parity bit, so it is only meaningful once in STOP.
    assign newParityErr = (PARITY_EN != 0) &&
                          ((^shift_q ^ parityBit_q) != 1'(PARITY_ODD));

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parityBit_d = parityBit_q;
        data_d      = data_q;
        valid_d     = valid_q;
        parityErr_d = parityErr_q;
        frameErr_d  = frameErr_q;
        overrun_d   = overrun_q;
        frameDone   = 1'b0;

        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (!bus.din) begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d = {bus.din, shift_q[DATA_W-1:1]};
                    if (bitCnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    parityBit_d = bus.din;
                    state_d     = STOP;
                end
                STOP: begin
                    frameDone = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // A consumer taking the held word on the completion edge makes room for the new one.
        if (frameDone) begin
            if (!valid_q || bus.ready) begin
                data_d      = shift_q;
                parityErr_d = newParityErr;
                frameErr_d  = !bus.din;
                valid_d     = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = parityErr_q;
    assign bus.frame_err  = frameErr_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed self-checking bench for serial_frame_receiver with default parameters
// (8 data bits, even parity enabled).
module tb_serial_frame_receiver;
    logic clk;
    logic rst;
    int   errorCount;
    int   checkCount;

    serial_frame_receiver_if #(.DATA_W(8)) bus ();

    serial_frame_receiver #(
        .DATA_W    (8),
        .PARITY_EN (1),
        .PARITY_ODD(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic e, input logic d, input logic r);
        bus.en    = e;
        bus.din   = d;
        bus.ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Start bit, 8 data bits LSB-first and the parity bit, one strobe each.
    task automatic sendHead(input logic [7:0] data, input logic parityBit, input logic r);
        logic [7:0] bits;
        bits = data;
        applyStimulus(1'b1, 1'b0, r);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, bits[i], r);
        applyStimulus(1'b1, parityBit, r);
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic parityBit,
                             input logic stopBit, input logic r);
        sendHead(data, parityBit, r);
        applyStimulus(1'b1, stopBit, r);
    endtask

    initial begin
        logic [7:0] slowBits;
        errorCount = 0;
        checkCount = 0;
        bus.en     = 1'b1;
        bus.din    = 1'b0;
        bus.ready  = 1'b1;
        rst        = 1'b1;

        // Reset with en=1/din=0 driven: reset must win over a start bit.
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst_data",    {8'h00, bus.data_out}, 16'h0000);
        checkOutput("rst_valid",   {15'd0, bus.valid},    16'd0);
        checkOutput("rst_perr",    {15'd0, bus.parity_err}, 16'd0);
        checkOutput("rst_ferr",    {15'd0, bus.frame_err},  16'd0);
        checkOutput("rst_ovr",     {15'd0, bus.overrun},    16'd0);
        checkOutput("rst_busy",    {15'd0, bus.busy},       16'd0);
        rst = 1'b0;

        // Idle: din=0 without strobe must not start a frame.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("noen_idle_busy", {15'd0, bus.busy}, 16'd0);

        // Basic 0xA5 frame, checking latency: nothing valid before the stop edge.
        sendHead(8'hA5, 1'b0, 1'b0);
        checkOutput("pre_stop_valid", {15'd0, bus.valid}, 16'd0);
        checkOutput("pre_stop_busy",  {15'd0, bus.busy},  16'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("a5_data",  {8'h00, bus.data_out},   16'h00A5);
        checkOutput("a5_valid", {15'd0, bus.valid},      16'd1);
        checkOutput("a5_perr",  {15'd0, bus.parity_err}, 16'd0);
        checkOutput("a5_ferr",  {15'd0, bus.frame_err},  16'd0);
        checkOutput("a5_busy",  {15'd0, bus.busy},       16'd0);
        checkOutput("a5_ovr",   {15'd0, bus.overrun},    16'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("a5_pop_valid", {15'd0, bus.valid},    16'd0);
        checkOutput("a5_pop_data",  {8'h00, bus.data_out}, 16'h00A5);

        // Wrong parity bit: delivered with parity_err.
        sendFrame(8'hA5, 1'b1, 1'b1, 1'b0);
        checkOutput("perr_data",  {8'h00, bus.data_out},   16'h00A5);
        checkOutput("perr_valid", {15'd0, bus.valid},      16'd1);
        checkOutput("perr_flag",  {15'd0, bus.parity_err}, 16'd1);
        checkOutput("perr_ferr",  {15'd0, bus.frame_err},  16'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("perr_pop_valid", {15'd0, bus.valid},      16'd0);
        checkOutput("perr_pop_hold",  {15'd0, bus.parity_err}, 16'd1);

        // Stop bit sampled as 0: delivered with frame_err.
        sendFrame(8'hA5, 1'b0, 1'b0, 1'b0);
        checkOutput("ferr_flag",  {15'd0, bus.frame_err},  16'd1);
        checkOutput("ferr_valid", {15'd0, bus.valid},      16'd1);
        checkOutput("ferr_perr",  {15'd0, bus.parity_err}, 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("ferr_pop_valid", {15'd0, bus.valid}, 16'd0);

        // Consumer takes the held 0xA5 on the same edge 0x3C completes.
        sendFrame(8'hA5, 1'b0, 1'b1, 1'b0);
        sendHead(8'h3C, 1'b0, 1'b0);
        checkOutput("swap_hold_data", {8'h00, bus.data_out}, 16'h00A5);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("swap_data",  {8'h00, bus.data_out}, 16'h003C);
        checkOutput("swap_valid", {15'd0, bus.valid},    16'd1);
        checkOutput("swap_ovr",   {15'd0, bus.overrun},  16'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("swap_pop_valid", {15'd0, bus.valid}, 16'd0);

        // Consumer stalled across two frames: second frame dropped, overrun sticks.
        sendFrame(8'hA5, 1'b0, 1'b1, 1'b0);
        sendFrame(8'h3C, 1'b0, 1'b1, 1'b0);
        checkOutput("ovr_data",  {8'h00, bus.data_out}, 16'h00A5);
        checkOutput("ovr_valid", {15'd0, bus.valid},    16'd1);
        checkOutput("ovr_flag",  {15'd0, bus.overrun},  16'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("ovr_pop_valid", {15'd0, bus.valid},   16'd0);
        checkOutput("ovr_pop_flag",  {15'd0, bus.overrun}, 16'd1);

        // Reset after start + 3 data bits of 0xA5, then a clean 0x3C frame.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("mid_busy_before", {15'd0, bus.busy}, 16'd1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        checkOutput("mid_rst_busy",  {15'd0, bus.busy},    16'd0);
        checkOutput("mid_rst_valid", {15'd0, bus.valid},   16'd0);
        checkOutput("mid_rst_ovr",   {15'd0, bus.overrun}, 16'd0);
        checkOutput("mid_rst_data",  {8'h00, bus.data_out}, 16'h0000);
        sendFrame(8'h3C, 1'b0, 1'b1, 1'b0);
        checkOutput("fresh_data",  {8'h00, bus.data_out},   16'h003C);
        checkOutput("fresh_valid", {15'd0, bus.valid},      16'd1);
        checkOutput("fresh_perr",  {15'd0, bus.parity_err}, 16'd0);
        checkOutput("fresh_ferr",  {15'd0, bus.frame_err},  16'd0);
        // Ready is honoured on an en=0 cycle.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("noen_pop_valid", {15'd0, bus.valid}, 16'd0);

        // 0xA5 with en toggling: each bit held across a strobe and a frozen cycle.
        slowBits = 8'hA5;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, slowBits[i], 1'b0);
            applyStimulus(1'b0, slowBits[i], 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("slow_pre_stop_valid", {15'd0, bus.valid}, 16'd0);
        checkOutput("slow_pre_stop_busy",  {15'd0, bus.busy},  16'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("slow_data",  {8'h00, bus.data_out},   16'h00A5);
        checkOutput("slow_valid", {15'd0, bus.valid},      16'd1);
        checkOutput("slow_perr",  {15'd0, bus.parity_err}, 16'd0);
        checkOutput("slow_ferr",  {15'd0, bus.frame_err},  16'd0);
        checkOutput("slow_busy",  {15'd0, bus.busy},       16'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("slow_hold_valid", {15'd0, bus.valid}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame (legal range 4..16).
REQ-002 Parameter PARITY_EN, default 1, 1 = a parity bit follows the data bits, 0 = no parity bit.
REQ-003 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  bit strobe; din is sampled only on rising edges where en=1.
REQ-007 din  input  1  serial bit stream, LSB-first framing, idle level 1.
REQ-008 ready  input  1  consumer accepts the held word when ready=1 and valid=1.
REQ-009 data_out  output  DATA_W  last accepted frame's data bits, bit 0 = first data bit received.
REQ-010 valid  output  1  data_out and error flags hold an unconsumed frame.
REQ-011 parity_err  output  1  parity mismatch on the held frame; always 0 when PARITY_EN=0.
REQ-012 frame_err  output  1  stop bit of the held frame sampled as 0.
REQ-013 overrun  output  1  sticky flag: a completed frame was dropped.
REQ-014 busy  output  1  1 whenever the FSM is not in IDLE.

Function
REQ-015 FSM states: IDLE, DATA, PARITY, STOP; transitions occur only on edges with en=1.
REQ-016 IDLE: din=0 goes to DATA with the bit counter cleared; din=1 stays in IDLE.
REQ-017 DATA: each strobe shifts din into the MSB of a DATA_W shift register, moving existing bits right; after exactly DATA_W strobes, go to PARITY if PARITY_EN=1, else STOP.
REQ-018 PARITY: capture the parity bit; mismatch means XOR of data bits and parity bit is not equal to PARITY_ODD; then go to STOP.
REQ-019 STOP: sample the stop bit, complete the frame, return to IDLE on the same edge.
REQ-020 Frame completion: if valid=0, or ready=1 on the same edge, load data_out, parity_err, frame_err and set valid=1.
REQ-021 Frame completion while valid=1 and ready=0: discard the new frame, keep the held outputs unchanged, set overrun=1.
REQ-022 Handshake: valid=1 and ready=1 with no completion on that edge clears valid next cycle; data_out and the flags hold their last value.
REQ-023 A frame with frame_err or parity_err is still delivered with valid=1; errors never block delivery.
REQ-024 overrun stays 1 until rst.
REQ-025 Latency: valid rises on the clock edge that samples the stop bit; no additional pipeline delay.
REQ-026 en=0 cycles freeze the FSM, counter and shift register; ready handling still occurs on those cycles.
REQ-027 busy is combinationally derived from state and equals (state != IDLE).

Reset
REQ-028 rst=1 at a rising edge forces IDLE, clears the counter and the shift register, and sets data_out=0, valid=0, parity_err=0, frame_err=0, overrun=0; busy=0.
REQ-029 rst takes priority over en, din and ready.
REQ-030 rst mid-frame discards the partial frame; the next start bit begins a fresh frame.

Verification
REQ-031 Defaults, en=1 every cycle, din = 0, 1,0,1,0,0,1,0,1, 0, 1 (start, 0xA5 LSB-first, even parity 0, stop) -> after the stop edge: data_out=0xA5, valid=1, parity_err=0, frame_err=0, busy=0.
REQ-032 Same frame with parity bit 1 -> data_out=0xA5, valid=1, parity_err=1; the same frame with stop bit 0 -> frame_err=1, valid=1.
REQ-033 Hold ready=0 and send 0xA5 then 0x3C -> data_out stays 0xA5, valid=1, overrun=1; then pulse ready=1 -> valid=0 next cycle, overrun remains 1.
REQ-034 Send 0x3C while ready=1 on the completion edge of a held 0xA5 -> data_out=0x3C, valid=1, overrun=0.
REQ-035 Apply rst after the start bit and 3 data bits -> busy=0, valid=0; then send a full 0x3C frame -> data_out=0x3C, valid=1, no errors.
REQ-036 en toggled 1,0,1,0,... with each bit held over 2 cycles for the 0xA5 frame -> same result as REQ-031; the FSM does not advance on en=0 cycles.
